ntt_stage_scheduler: RTL and testbench
======================================

Name: ntt_stage_scheduler

Overview:
Sequencer for the butterfly array and its coefficient memory banks. On a start command it steps through every NTT stage, or a single pointwise-multiply pass, issuing one row per cycle. Per row it drives read address, twiddle ROM index, mode and swap, then issues the matching write-back after the fixed pipeline latency. It drains the pipeline between stages so a stage never reads rows still in flight from the previous stage.

Parameters:
ADDR_W, 6, coefficient bank row-address width
ROWS, 64, rows processed per stage (≤ 2**ADDR_W)
NUM_STAGES, 8, NTT stages per transform
LUT_SIZE, 1360, twiddle ROM depth
W_MUL_BASE, 1024, ROM index of first row of multiply-mode constants
BF_LATENCY, 4, cycles from butterfly-array inputs (incl. ROM address) to A_out/B_out

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  command strobe, sampled only in IDLE
op  in  1  0 = NTT (all stages), 1 = pointwise multiply (one pass)
swap_cfg  in  1  swap value for multiply pass, latched at start
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle pulse when last write-back issued
rd_en  out  1  bank read strobe
rd_addr  out  ADDR_W  bank read row
w_idx  out  $clog2(LUT_SIZE)  twiddle ROM address, aligned with rd_en
bf_mode  out  1  butterfly-array mode, held for whole operation
bf_swap  out  1  butterfly-array swap, held for whole operation
stage  out  $clog2(NUM_STAGES)  current stage, for external address permutation
wr_en  out  1  bank write strobe
wr_addr  out  ADDR_W  bank write row

Behaviour:
- PIPE = BF_LATENCY + 1 (1-cycle bank read + array latency).
- Reset (asynchronous, reset=0): state IDLE, all outputs 0, row/stage/drain counters 0, write delay line cleared. Reset mid-operation abandons the transform; no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → latch op; bf_mode=op; bf_swap = op ? swap_cfg : 0; stage=0; row=0; go RUN. start ignored in every other state.
- RUN: rd_en=1, rd_addr=row, w_idx = op ? W_MUL_BASE+row : stage*ROWS+row. row increments each cycle. At row=ROWS-1 → DRAIN with drain counter=0.
- DRAIN: rd_en=0. Lasts exactly PIPE cycles. Final cycle: if op=0 and stage<NUM_STAGES-1, then stage+1, row=0, → RUN; otherwise → DONE.
- DONE: done=1 for one cycle → IDLE. busy falls with entry to IDLE.
- Write path: {rd_en, rd_addr} passes through a PIPE-deep shift register to {wr_en, wr_addr}. A write is issued exactly PIPE cycles after its read, and the final write lands in the last DRAIN cycle.
- Timing with defaults (start at cycle 0): each stage takes ROWS+PIPE = 69 cycles. NTT: RUN 1–64, DRAIN 65–69, stage 1 RUN from 70; done at cycle 553. Multiply: done at cycle 70.
- Width rules: w_idx computed at full width, no wrap. Legal configs satisfy NUM_STAGES*ROWS ≤ W_MUL_BASE and W_MUL_BASE+ROWS ≤ LUT_SIZE; checked with a simulation-only assertion.
- bf_mode, bf_swap and stage change only at state transitions, never mid-stage.

Optional Feature:
Macro NTT_SCHED_PERF_EN.
- Defined: adds output cycle_count [31:0]. Cleared when start is accepted, increments each cycle busy=1, saturates at 2**32-1, holds after done until the next start, cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-RUN (cycle 30 of stage 2) → all outputs 0 immediately, no done; a fresh start gives a full 552-cycle run.
- NTT, op=0, start at cycle 0 → rd_en high 64 cycles per stage, 8 stages. w_idx for stage 3 row 5 is 197. First wr_en at cycle 6 with wr_addr 0. done pulse at 553 only.
- Multiply, op=1, swap_cfg=1 → bf_mode=1 and bf_swap=1 throughout. w_idx runs 1024..1087. done at 70. stage stays 0.
- start held high during busy, plus a back-to-back start in the done cycle → both ignored; start in the following IDLE cycle is accepted.
- Drain check: no rd_en in any cycle where a wr_en from the previous stage is still pending. Last write of each stage occurs PIPE cycles after its read.
- With NTT_SCHED_PERF_EN, NTT run → cycle_count = 553 after done. Stays 553 while idle, returns to 0 on the next start.

Source files
------------

// File: rtl/ntt_stage_scheduler.sv
// rtl/ntt_stage_scheduler.sv - row/stage sequencer for the NTT butterfly array and coefficient banks
// Optional feature: define NTT_SCHED_PERF_EN to add the cycle_count output.
// Ports:
//   clk, reset (async, active-low)
//   start, op, swap_cfg        : command (sampled in IDLE only)
//   busy, done                 : status (done is a one-cycle pulse)
//   rd_en, rd_addr, w_idx      : bank read row and twiddle ROM index, aligned
//   bf_mode, bf_swap, stage    : held per operation / per stage
//   wr_en, wr_addr             : write-back, PIPE cycles after the matching read
//   cycle_count                : busy-cycle counter (NTT_SCHED_PERF_EN only)
module ntt_stage_scheduler #(
    parameter int ADDR_W     = 6,
    parameter int ROWS       = 64,
    parameter int NUM_STAGES = 8,
    parameter int LUT_SIZE   = 1360,
    parameter int W_MUL_BASE = 1024,
    parameter int BF_LATENCY = 4,
    localparam int W_IDX_W   = $clog2(LUT_SIZE),
    localparam int STAGE_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic               swap_cfg,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [W_IDX_W-1:0] w_idx,
    output logic               bf_mode,
    output logic               bf_swap,
    output logic [STAGE_W-1:0] stage,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr
`ifdef NTT_SCHED_PERF_EN
    ,
    output logic [31:0]        cycle_count
`endif
);

    // One cycle of bank read plus the butterfly-array latency.
    localparam int PIPE    = BF_LATENCY + 1;
    localparam int DRAIN_W = $clog2(PIPE + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 op_q;
    logic [ADDR_W-1:0]    row_q;
    logic [STAGE_W-1:0]   stage_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic [ADDR_W:0]      wr_pipe [PIPE];
    logic [31:0]          idx_full;
    logic                 last_row;
    logic                 last_stage;
    logic                 last_drain;

    assign last_row   = (row_q == ADDR_W'(ROWS - 1));
    assign last_stage = (stage_q == STAGE_W'(NUM_STAGES - 1));
    assign last_drain = (drain_q == DRAIN_W'(PIPE - 1));
    assign stage      = stage_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_row) state_nxt = S_DRAIN;
            S_DRAIN: if (last_drain) state_nxt = (!op_q && !last_stage) ? S_RUN : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        rd_en    = (state == S_RUN);
        idx_full = op_q ? (W_MUL_BASE + 32'(row_q))
                        : (32'(stage_q) * ROWS + 32'(row_q));
        rd_addr  = rd_en ? row_q : '0;
        w_idx    = rd_en ? idx_full[W_IDX_W-1:0] : '0;
    end

    // Row, stage and drain counters; mode/swap only move when a start is accepted,
    // stage only moves on the DRAIN -> RUN transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= 1'b0;
            bf_mode <= 1'b0;
            bf_swap <= 1'b0;
            stage_q <= '0;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        bf_mode <= op;
                        bf_swap <= op & swap_cfg;
                        stage_q <= '0;
                        row_q   <= '0;
                    end
                end
                S_RUN: begin
                    row_q   <= last_row ? '0 : row_q + 1'b1;
                    drain_q <= '0;
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (last_drain && !op_q && !last_stage) begin
                        stage_q <= stage_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-back delay line: each read reappears as a write exactly PIPE cycles later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE; i++) begin
                wr_pipe[i] <= '0;
            end
        end else begin
            wr_pipe[0] <= {rd_en, rd_addr};
            for (int i = 1; i < PIPE; i++) begin
                wr_pipe[i] <= wr_pipe[i-1];
            end
        end
    end

    assign wr_en   = wr_pipe[PIPE-1][ADDR_W];
    assign wr_addr = wr_pipe[PIPE-1][ADDR_W-1:0];

`ifdef NTT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (state == S_IDLE && start) begin
            cycle_count <= '0;
        end else if (busy && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // Stage twiddles must sit below the multiply constants, which must fit the ROM.
    localparam bit CFG_OK = (NUM_STAGES * ROWS <= W_MUL_BASE) &&
                            (W_MUL_BASE + ROWS <= LUT_SIZE) &&
                            (ROWS <= 2 ** ADDR_W) && (ROWS >= 1);
    cfg_legal_a: assert property (@(posedge clk) CFG_OK);
`endif

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// tb/tb_ntt_stage_scheduler.sv - self-checking bench for ntt_stage_scheduler
module tb_ntt_stage_scheduler;

    localparam int ADDR_W     = 6;
    localparam int ROWS       = 64;
    localparam int NUM_STAGES = 8;
    localparam int LUT_SIZE   = 1360;
    localparam int W_MUL_BASE = 1024;
    localparam int BF_LATENCY = 4;
    localparam int PIPE       = BF_LATENCY + 1;
    localparam int PERIOD     = ROWS + PIPE;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              op = 1'b0;
    logic              swap_cfg = 1'b0;
    logic              busy, done, rd_en, wr_en, bf_mode, bf_swap;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [10:0]       w_idx;
    logic [2:0]        stage;
`ifdef NTT_SCHED_PERF_EN
    logic [31:0]       cycle_count;
`endif

    ntt_stage_scheduler #(
        .ADDR_W(ADDR_W), .ROWS(ROWS), .NUM_STAGES(NUM_STAGES),
        .LUT_SIZE(LUT_SIZE), .W_MUL_BASE(W_MUL_BASE), .BF_LATENCY(BF_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .swap_cfg(swap_cfg),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .w_idx(w_idx),
        .bf_mode(bf_mode), .bf_swap(bf_swap), .stage(stage),
        .wr_en(wr_en), .wr_addr(wr_addr)
`ifdef NTT_SCHED_PERF_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit op;
        bit swap;
        bit hold;
        int nst;
        int exp_done;
        int exp_reads;
        bit exp_mode;
        bit exp_swap;
    } vec_t;

    typedef struct { int addr; int widx; int stg; } rd_t;
    typedef struct { int due; int addr; int stg; } wr_t;

    vec_t tbl[5];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_w_idx"}, w_idx, 0);
        chk({tag, "_bf_mode"}, bf_mode, 0);
        chk({tag, "_bf_swap"}, bf_swap, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
`ifdef NTT_SCHED_PERF_EN
        chk({tag, "_cycle_count"}, cycle_count, 0);
`endif
    endtask

    // Cycle 0 is the cycle in which start is presented; checks cover cycles 0..exp_done+1.
    task automatic run_vec(input vec_t v);
        rd_t rq[$];
        wr_t wq[$];
        rd_t re;
        wr_t we;
        int  reads = 0;
        for (int s = 0; s < v.nst; s++) begin
            for (int r = 0; r < ROWS; r++) begin
                re.addr = r;
                re.widx = v.op ? W_MUL_BASE + r : s * ROWS + r;
                re.stg  = s;
                rq.push_back(re);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; op = v.op; swap_cfg = v.swap;
        for (int c = 0; c <= v.exp_done + 1; c++) begin
            int k, s, r, exp_stage;
            bit exp_rd, exp_busy, stale;
            @(negedge clk);
            k = (c >= 1) ? c - 1 : 0;
            s = k / PERIOD;
            r = k % PERIOD;
            exp_rd   = (c >= 1) && (c <= v.nst * PERIOD) && (r < ROWS);
            exp_busy = (c >= 1) && (c <= v.exp_done);
            chk("rd_en", rd_en, exp_rd);
            chk("busy", busy, exp_busy);
            chk("done", done, c == v.exp_done);
            if (c >= 1) begin
                exp_stage = v.op ? 0 : ((c <= v.nst * PERIOD) ? s : v.nst - 1);
                chk("stage", stage, exp_stage);
                chk("bf_mode", bf_mode, v.exp_mode);
                chk("bf_swap", bf_swap, v.exp_swap);
`ifdef NTT_SCHED_PERF_EN
                chk("cycle_count", cycle_count, c - 1);
`endif
            end
            if (rd_en) begin
                reads++;
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    re = rq.pop_front();
                    chk("rd_addr", rd_addr, re.addr);
                    chk("w_idx", w_idx, re.widx);
                    stale = 1'b0;
                    foreach (wq[i]) if (wq[i].stg != re.stg) stale = 1'b1;
                    chk("drain_overlap", stale, 0);
                    we.due = c + PIPE; we.addr = re.addr; we.stg = re.stg;
                    wq.push_back(we);
                end
            end
            if (wq.size() > 0 && wq[0].due == c) begin
                we = wq.pop_front();
                chk("wr_en", wr_en, 1);
                chk("wr_addr", wr_addr, we.addr);
            end else begin
                chk("wr_en_idle", wr_en, 0);
            end
            if (!v.op && c == 1 + 3 * PERIOD + 5) chk("w_idx_s3r5", w_idx, 197);
            if (c == 6) begin
                chk("first_wr_en", wr_en, 1);
                chk("first_wr_addr", wr_addr, 0);
            end
            @(posedge clk); #1;
            if (v.hold) begin
                op = ~v.op; swap_cfg = ~v.swap;
            end else begin
                start = 1'b0;
            end
        end
        chk("read_count", reads, v.exp_reads);
        chk("rd_left", rq.size(), 0);
        chk("wr_left", wq.size(), 0);
        @(negedge clk);
        if (v.hold) begin
            // start stayed high into the first IDLE cycle, so a new operation began
            chk("restart_busy", busy, 1);
            chk("restart_mode", bf_mode, !v.op);
            start = 1'b0;
            reset = 1'b0;
            #1;
            check_all_zero("hold_reset");
            @(posedge clk); #1;
            reset = 1'b1;
        end else begin
            chk("idle_busy", busy, 0);
`ifdef NTT_SCHED_PERF_EN
            chk("count_hold", cycle_count, v.exp_done);
`endif
        end
    endtask

    initial begin
        tbl[0] = '{op: 1'b0, swap: 1'b0, hold: 1'b0, nst: 8, exp_done: 553, exp_reads: 512, exp_mode: 1'b0, exp_swap: 1'b0};
        tbl[1] = '{op: 1'b1, swap: 1'b1, hold: 1'b0, nst: 1, exp_done: 70,  exp_reads: 64,  exp_mode: 1'b1, exp_swap: 1'b1};
        tbl[2] = '{op: 1'b1, swap: 1'b0, hold: 1'b0, nst: 1, exp_done: 70,  exp_reads: 64,  exp_mode: 1'b1, exp_swap: 1'b0};
        tbl[3] = '{op: 1'b0, swap: 1'b1, hold: 1'b0, nst: 8, exp_done: 553, exp_reads: 512, exp_mode: 1'b0, exp_swap: 1'b0};
        tbl[4] = '{op: 1'b1, swap: 1'b1, hold: 1'b1, nst: 1, exp_done: 70,  exp_reads: 64,  exp_mode: 1'b1, exp_swap: 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Reset in the middle of stage 2, row 30 (cycle 169).
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; swap_cfg = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1 + 2 * PERIOD + 30 - 1) @(posedge clk);
        #2;
        chk("pre_reset_stage", stage, 2);
        chk("pre_reset_rd_addr", rd_addr, 30);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_no_done", done, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", busy, 0);
        run_vec(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
